// File: rtl/nabp_pkg.sv
// ----------------------------------------------------------------------------
// nabp_pkg
// Shared constants and helpers for the PE-array feed path.
//   NABP_DATA_LENGTH     default sample width (signed filtered samples)
//   NABP_NO_PARTITIONS   default partition count (= taps per channel)
//   NABP_PARTITION_SIZE  default partition size (= shift distance between taps)
//   nabp_taps_vec_w()    width of a packed tap vector
//   nabp_fill_max()      saturation value of a channel fill counter
//   nabp_clog2_min1()    $clog2 clamped to at least 1 bit
// ----------------------------------------------------------------------------
package nabp_pkg;

  localparam int NABP_DATA_LENGTH    = 16;
  localparam int NABP_NO_PARTITIONS  = 8;
  localparam int NABP_PARTITION_SIZE = 16;

  // Packed tap vector: tap0 in the LSBs, tap[no_taps-1] in the MSBs.
  function automatic int nabp_taps_vec_w(input int no_taps, input int data_len);
    return no_taps * data_len;
  endfunction

  // Once a channel has seen this many shifts every tap holds a real sample,
  // so counting further adds no information.
  function automatic int nabp_fill_max(input int no_taps, input int taps_width);
    return (no_taps - 1) * taps_width + 1;
  endfunction

  function automatic int nabp_clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/nabp_tap_fill_ctrl.sv
// ----------------------------------------------------------------------------
// nabp_tap_fill_ctrl
// Per-channel write pointer and fill counter for the tap delay line.
// A clear in the same cycle as a shift is applied first, so the shift lands
// in an empty channel (fill=1, ptr=1 afterwards).
// Ports:
//   clk           clock, rising edge
//   reset_n       asynchronous active-low reset
//   shift_i       a sample is shifted into this channel this cycle
//   clear_i       this channel is emptied this cycle
//   ptr_o         storage address offset used by this cycle's shift
//   valid_mask_o  taps_valid pattern the channel has after this cycle's shift
// ----------------------------------------------------------------------------
module nabp_tap_fill_ctrl
  import nabp_pkg::*;
#(
  parameter int pNoTaps    = NABP_NO_PARTITIONS,
  parameter int pTapsWidth = NABP_PARTITION_SIZE,
  localparam int PW        = nabp_clog2_min1(pTapsWidth)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               shift_i,
  input  logic               clear_i,
  output logic [PW-1:0]      ptr_o,
  output logic [pNoTaps-1:0] valid_mask_o
);

  localparam int FMAX = nabp_fill_max(pNoTaps, pTapsWidth);
  localparam int FW   = $clog2(FMAX + 1);

  logic [PW-1:0] ptr_q, ptr_d, ptr_eff;
  logic [FW-1:0] fill_q, fill_d, fill_eff, fill_new;

  always_comb begin
    // Clear-before-shift: the shift sees an already-emptied channel.
    ptr_eff  = clear_i ? '0 : ptr_q;
    fill_eff = clear_i ? '0 : fill_q;
    fill_new = (fill_eff == FW'(FMAX)) ? fill_eff : fill_eff + FW'(1);

    ptr_d  = ptr_q;
    fill_d = fill_q;
    if (shift_i) begin
      ptr_d  = (ptr_eff == PW'(pTapsWidth - 1)) ? '0 : ptr_eff + PW'(1);
      fill_d = fill_new;
    end else if (clear_i) begin
      ptr_d  = '0;
      fill_d = '0;
    end

    // Tap k holds a real sample once more than k*pTapsWidth shifts happened.
    valid_mask_o = '0;
    for (int k = 0; k < pNoTaps; k++) begin
      valid_mask_o[k] = (fill_new > FW'(k * pTapsWidth));
    end
  end

  assign ptr_o = ptr_eff;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q  <= '0;
      fill_q <= '0;
    end else begin
      ptr_q  <= ptr_d;
      fill_q <= fill_d;
    end
  end

endmodule

// File: rtl/nabp_pe_tap_buffer.sv
// ----------------------------------------------------------------------------
// nabp_pe_tap_buffer
// Multi-channel tap delay line between the filtered-RAM read and the PE array.
// Each channel (interleaved angle) has its own delay line; taps[k] of a
// channel is the sample shifted in k*pTapsWidth shifts before taps[0].
// Ports:
//   clk, reset_n   clock / asynchronous active-low reset
//   shift_en       shift shift_in into channel shift_ch
//   shift_ch       target channel of the shift
//   shift_in       signed sample
//   clear          empty channel clear_ch (synchronous)
//   clear_ch       channel to clear
//   clear_all      empty every channel (synchronous)
//   taps           taps of out_ch, tap0 in the LSBs, invalid taps read 0
//   taps_valid     bit k set when taps[k] holds a real sample
//   out_valid      taps/taps_valid/out_ch were updated by a shift this cycle
//   out_ch         channel the taps belong to
// ----------------------------------------------------------------------------
module nabp_pe_tap_buffer
  import nabp_pkg::*;
#(
  parameter int pNoTaps     = NABP_NO_PARTITIONS,
  parameter int pTapsWidth  = NABP_PARTITION_SIZE,
  parameter int pDataLength = NABP_DATA_LENGTH,
  parameter int pNoChannels = 2,
  parameter int pChLength   = 1
) (
  input  logic                                               clk,
  input  logic                                               reset_n,
  input  logic                                               shift_en,
  input  logic [pChLength-1:0]                               shift_ch,
  input  logic signed [pDataLength-1:0]                      shift_in,
  input  logic                                               clear,
  input  logic [pChLength-1:0]                               clear_ch,
  input  logic                                               clear_all,
  output logic [nabp_taps_vec_w(pNoTaps, pDataLength)-1:0]   taps,
  output logic [pNoTaps-1:0]                                 taps_valid,
  output logic                                               out_valid,
  output logic [pChLength-1:0]                               out_ch
);

  localparam int PW    = nabp_clog2_min1(pTapsWidth);
  localparam int DEPTH = pNoChannels * pTapsWidth;
  localparam int AW    = nabp_clog2_min1(DEPTH);
  localparam int TW    = nabp_taps_vec_w(pNoTaps, pDataLength);

  logic                                  shift_ok;
  logic [pChLength-1:0]                  sel;
  logic [pNoChannels-1:0]                ch_shift;
  logic [pNoChannels-1:0]                ch_clear;
  logic [PW-1:0]                         ch_ptr  [pNoChannels];
  logic [pNoTaps-1:0]                    ch_mask [pNoChannels];
  logic [pNoTaps-1:0]                    mask_sel;
  logic [AW-1:0]                         addr;
  logic [pNoTaps-1:0][pDataLength-1:0]   rd;

  logic [TW-1:0]          taps_q;
  logic [pNoTaps-1:0]     taps_valid_q;
  logic                   out_valid_q;
  logic [pChLength-1:0]   out_ch_q;

  // Out-of-range channel requests are dropped entirely.
  assign shift_ok = shift_en && (int'(shift_ch) < pNoChannels);
  assign sel      = shift_ok ? shift_ch : '0;
  assign mask_sel = ch_mask[sel];
  assign addr     = AW'(int'(sel) * pTapsWidth + int'(ch_ptr[sel]));

  for (genvar c = 0; c < pNoChannels; c++) begin : g_ch
    assign ch_shift[c] = shift_ok && (shift_ch == pChLength'(c));
    assign ch_clear[c] = clear_all || (clear && (clear_ch == pChLength'(c)));

    nabp_tap_fill_ctrl #(
      .pNoTaps    (pNoTaps),
      .pTapsWidth (pTapsWidth)
    ) u_fill_ctrl (
      .clk          (clk),
      .reset_n      (reset_n),
      .shift_i      (ch_shift[c]),
      .clear_i      (ch_clear[c]),
      .ptr_o        (ch_ptr[c]),
      .valid_mask_o (ch_mask[c])
    );
  end

  // Stage 0 is the incoming sample itself; stage k (k>=1) is a RAM that, at
  // address {ch,ptr}, holds what stage k-1 held there one lap earlier.
  // Read-before-write: rd[k] is the old word, pushed into stage k+1.
  assign rd[0] = shift_in;

  for (genvar k = 1; k < pNoTaps; k++) begin : g_stage
    logic [pDataLength-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
      if (shift_ok) begin
        mem[addr] <= rd[k-1];
      end
    end

    assign rd[k] = mem[addr];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      taps_q       <= '0;
      taps_valid_q <= '0;
      out_valid_q  <= 1'b0;
      out_ch_q     <= '0;
    end else if (shift_ok) begin
      out_valid_q  <= 1'b1;
      out_ch_q     <= shift_ch;
      taps_valid_q <= mask_sel;
      // Masking hides unreset RAM contents and pre-clear history.
      for (int k = 0; k < pNoTaps; k++) begin
        taps_q[k*pDataLength +: pDataLength] <= mask_sel[k] ? rd[k] : '0;
      end
    end else begin
      out_valid_q <= 1'b0;
      if (ch_clear[out_ch_q]) begin
        taps_q       <= '0;
        taps_valid_q <= '0;
      end
    end
  end

  assign taps       = taps_q;
  assign taps_valid = taps_valid_q;
  assign out_valid  = out_valid_q;
  assign out_ch     = out_ch_q;

endmodule

// File: tb/tb_nabp_pe_tap_buffer.sv
module tb_nabp_pe_tap_buffer;

  localparam int NT = 3;
  localparam int TWD = 4;
  localparam int DL = 16;
  localparam int NC = 2;
  localparam int CL = 1;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               shift_en;
  logic [CL-1:0]      shift_ch;
  logic signed [DL-1:0] shift_in;
  logic               clear;
  logic [CL-1:0]      clear_ch;
  logic               clear_all;
  logic [NT*DL-1:0]   taps;
  logic [NT-1:0]      taps_valid;
  logic               out_valid;
  logic [CL-1:0]      out_ch;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  nabp_pe_tap_buffer #(
    .pNoTaps     (NT),
    .pTapsWidth  (TWD),
    .pDataLength (DL),
    .pNoChannels (NC),
    .pChLength   (CL)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .shift_en   (shift_en),
    .shift_ch   (shift_ch),
    .shift_in   (shift_in),
    .clear      (clear),
    .clear_ch   (clear_ch),
    .clear_all  (clear_all),
    .taps       (taps),
    .taps_valid (taps_valid),
    .out_valid  (out_valid),
    .out_ch     (out_ch)
  );

  typedef struct {
    logic        en;
    logic        ch;
    logic [15:0] din;
    logic        clr;
    logic        cch;
    logic        call;
    logic        ev;
    logic        ech;
    logic [47:0] et;
    logic [2:0]  etv;
  } vec_t;

  vec_t tbl_a[$];
  vec_t tbl_c[$];

  function automatic vec_t mk(logic en, logic ch, int din, logic clr, logic cch,
                              logic call, logic ev, logic ech,
                              int t2, int t1, int t0, logic [2:0] etv);
    vec_t v;
    v.en = en; v.ch = ch; v.din = 16'(din);
    v.clr = clr; v.cch = cch; v.call = call;
    v.ev = ev; v.ech = ech;
    v.et = {16'(t2), 16'(t1), 16'(t0)};
    v.etv = etv;
    return v;
  endfunction

  // Reference: after the j-th shift since clear, tap k is the sample from
  // k*4 shifts earlier, present once j > 4k; sample values are base+j.
  function automatic logic [47:0] ref_taps(int base, int j);
    logic [47:0] r;
    r = '0;
    for (int k = 0; k < NT; k++)
      if (j > TWD * k) r[k*16 +: 16] = 16'(base + j - TWD * k);
    return r;
  endfunction

  function automatic logic [2:0] ref_tv(int j);
    logic [2:0] r;
    r = '0;
    for (int k = 0; k < NT; k++) r[k] = (j > TWD * k);
    return r;
  endfunction

  task automatic check(string name, logic ev, logic ech, logic [47:0] et, logic [2:0] etv);
    n_vec++;
    if (out_valid !== ev || out_ch !== ech || taps !== et || taps_valid !== etv) begin
      n_err++;
      $display("FAIL %s: got valid=%0b ch=%0d taps=%h tv=%b, expected valid=%0b ch=%0d taps=%h tv=%b",
               name, out_valid, out_ch, taps, taps_valid, ev, ech, et, etv);
    end
  endtask

  task automatic apply(vec_t v, string name);
    @(negedge clk);
    shift_en  = v.en;
    shift_ch  = v.ch;
    shift_in  = v.din;
    clear     = v.clr;
    clear_ch  = v.cch;
    clear_all = v.call;
    @(posedge clk);
    #1;
    check(name, v.ev, v.ech, v.et, v.etv);
  endtask

  task automatic shift_chk(logic ch, int base, int j, string name);
    vec_t v;
    v = mk(1'b1, ch, base + j, 1'b0, 1'b0, 1'b0, 1'b1, ch, 0, 0, 0, 3'b000);
    v.et  = ref_taps(base, j);
    v.etv = ref_tv(j);
    apply(v, name);
  endtask

  initial begin
    // Single-channel fill 1..9, then hold, clear of another channel, clear_all.
    tbl_a.push_back(mk(1,0,1, 0,0,0, 1,0, 0,0,1, 3'b001));
    tbl_a.push_back(mk(1,0,2, 0,0,0, 1,0, 0,0,2, 3'b001));
    tbl_a.push_back(mk(1,0,3, 0,0,0, 1,0, 0,0,3, 3'b001));
    tbl_a.push_back(mk(1,0,4, 0,0,0, 1,0, 0,0,4, 3'b001));
    tbl_a.push_back(mk(1,0,5, 0,0,0, 1,0, 0,1,5, 3'b011));
    tbl_a.push_back(mk(1,0,6, 0,0,0, 1,0, 0,2,6, 3'b011));
    tbl_a.push_back(mk(1,0,7, 0,0,0, 1,0, 0,3,7, 3'b011));
    tbl_a.push_back(mk(1,0,8, 0,0,0, 1,0, 0,4,8, 3'b011));
    tbl_a.push_back(mk(1,0,9, 0,0,0, 1,0, 1,5,9, 3'b111));
    tbl_a.push_back(mk(0,0,0, 0,0,0, 0,0, 1,5,9, 3'b111));
    tbl_a.push_back(mk(0,0,0, 1,1,0, 0,0, 1,5,9, 3'b111));
    tbl_a.push_back(mk(0,0,0, 0,0,1, 0,0, 0,0,0, 3'b000));

    // Clear corner cases, entered after 10 interleaved shifts per channel.
    tbl_c.push_back(mk(1,1,211, 1,0,0, 1,1, 203,207,211, 3'b111));
    tbl_c.push_back(mk(1,0,7,   0,0,0, 1,0, 0,0,7,       3'b001));
    tbl_c.push_back(mk(1,1,212, 0,0,0, 1,1, 204,208,212, 3'b111));
    tbl_c.push_back(mk(1,0,42,  1,0,0, 1,0, 0,0,42,      3'b001));
    tbl_c.push_back(mk(1,0,43,  0,0,0, 1,0, 0,0,43,      3'b001));
    tbl_c.push_back(mk(1,1,50,  0,0,1, 1,1, 0,0,50,      3'b001));
    tbl_c.push_back(mk(1,0,44,  0,0,0, 1,0, 0,0,44,      3'b001));
    tbl_c.push_back(mk(0,0,0,   1,1,0, 0,0, 0,0,44,      3'b001));
    tbl_c.push_back(mk(0,0,0,   1,0,0, 0,0, 0,0,0,       3'b000));
    tbl_c.push_back(mk(1,0,45,  0,0,0, 1,0, 0,0,45,      3'b001));

    reset_n = 1'b0;
    shift_en = 1'b0; shift_ch = '0; shift_in = '0;
    clear = 1'b0; clear_ch = '0; clear_all = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset", 1'b0, 1'b0, 48'h0, 3'b000);
    @(negedge clk);
    reset_n = 1'b1;

    foreach (tbl_a[i]) apply(tbl_a[i], $sformatf("tbl_a[%0d]", i));

    for (int i = 1; i <= 10; i++) begin
      shift_chk(1'b0, 100, i, $sformatf("interleave ch0 #%0d", i));
      shift_chk(1'b1, 200, i, $sformatf("interleave ch1 #%0d", i));
    end

    foreach (tbl_c[i]) apply(tbl_c[i], $sformatf("tbl_c[%0d]", i));

    apply(mk(0,0,0, 0,0,1, 0,0, 0,0,0, 3'b000), "sat clear_all");
    for (int j = 1; j <= 100; j++)
      shift_chk(1'b0, 1000, j, $sformatf("saturate #%0d", j));

    // Asynchronous reset in the middle of a shift stream.
    @(negedge clk);
    shift_en = 1'b1; shift_ch = 1'b0; shift_in = 16'sd77;
    reset_n = 1'b0;
    #1;
    check("async reset immediate", 1'b0, 1'b0, 48'h0, 3'b000);
    @(posedge clk);
    #1;
    check("async reset held", 1'b0, 1'b0, 48'h0, 3'b000);
    @(negedge clk);
    reset_n = 1'b1;
    shift_en = 1'b0;
    apply(mk(1,0,5, 0,0,0, 1,0, 0,0,5, 3'b001), "post-reset shift 1");
    apply(mk(1,0,6, 0,0,0, 1,0, 0,0,6, 3'b001), "post-reset shift 2");

    @(negedge clk);
    shift_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
